elevador_multipiso: RTL and testbench

ELEVADOR_MULTIPISO -- requirements
Module: elevador_multipiso

---
 rtl/elevador_pkg.sv | 21 ++
 rtl/elevador_timer.sv | 29 ++
 rtl/elevador_multipiso.sv | 197 +++++++++++++++++++
 tb/tb_elevador_multipiso.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared types and default configuration for the multi-floor elevator controller.
// Contents: controller state enum, default parameter values.
// ELEVADOR_FAULT_EN adds the FAULT state to the enum.
package elevador_pkg;

  localparam int DEF_FLOORS      = 4;
  localparam int DEF_DOOR_CYCLES = 8;
  localparam int DEF_TRAVEL_MAX  = 64;

  typedef enum logic [2:0] {
    ST_HOMING = 3'd0,
    ST_IDLE   = 3'd1,
    ST_UP     = 3'd2,
    ST_DOWN   = 3'd3,
    ST_DOOR   = 3'd4
`ifdef ELEVADOR_FAULT_EN
    , ST_FAULT = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/elevador_timer.sv
// Loadable down-counter: load wins over count, counts down while en, saturates at zero.
// Ports: clk, rst (sync, active-high), load/load_val (restart), en (count), done (count==0).
// Latency: done reflects the registered count; no backpressure, inputs sampled every cycle.
module elevador_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/elevador_multipiso.sv
// Multi-floor elevator controller: homing, SCAN up/down service, timed door stops.
// Ports: clk, rst (sync, active-high), call/sw in; Mup, Mdown, door_open, floor_idx, pending, fault out.
// Latency: outputs registered, motor stops on the edge that samples the target sw bit; no backpressure.
// Option: define ELEVADOR_FAULT_EN for the travel watchdog, multi-switch detection and FAULT state.
module elevador_multipiso
  import elevador_pkg::*;
#(
  parameter int FLOORS      = DEF_FLOORS,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
  parameter int TRAVEL_MAX  = DEF_TRAVEL_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLOORS-1:0]          call,
  input  logic [FLOORS-1:0]          sw,
  output logic                       Mup,
  output logic                       Mdown,
  output logic                       door_open,
  output logic [$clog2(FLOORS)-1:0]  floor_idx,
  output logic [FLOORS-1:0]          pending,
  output logic                       fault
);

  localparam int FW = $clog2(FLOORS);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  if (FLOORS < 2 || FLOORS > 16 || DOOR_CYCLES < 1 || TRAVEL_MAX < 1) begin : g_bad_cfg
    $error("elevador_multipiso: parameter out of range");
  end

  state_t            state, state_n;
  logic              dir, dir_n;          // 1 = last travel direction was up
  logic              sw_any;
  logic [FW-1:0]     sw_idx;
  logic              any_above, any_below;
  logic              door_load, door_done;
  logic              stop_clr;
  logic [FW-1:0]     stop_floor;
  logic [FLOORS-1:0] call_eff, pending_n;

  // Lowest set switch wins when several read high at once.
  always_comb begin
    sw_any = |sw;
    sw_idx = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (sw[i]) sw_idx = FW'(i);
    end
  end

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (FW'(i) > floor_idx) any_above = any_above | pending[i];
      if (FW'(i) < floor_idx) any_below = any_below | pending[i];
    end
  end

  elevador_timer #(.W(DW)) u_door_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (door_load),
    .load_val (DW'(DOOR_CYCLES - 1)),
    .en       (state == ST_DOOR),
    .done     (door_done)
  );

`ifdef ELEVADOR_FAULT_EN
  localparam int WW = $clog2(TRAVEL_MAX + 1);

  logic [FLOORS-1:0] sw_prev;
  logic              wd_load, wd_done, sw_multi, fault_cond;

  // Watchdog restarts whenever the motor is off or any switch changes.
  assign wd_load    = !(Mup || Mdown) || (sw != sw_prev);
  assign sw_multi   = |(sw & (sw - FLOORS'(1)));
  assign fault_cond = sw_multi || (!wd_load && wd_done);

  elevador_timer #(.W(WW)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (WW'(TRAVEL_MAX - 1)),
    .en       (Mup || Mdown),
    .done     (wd_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_prev <= '0;
      fault   <= 1'b0;
    end else begin
      sw_prev <= sw;
      fault   <= (state_n == ST_FAULT);
    end
  end
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    dir_n      = dir;
    door_load  = 1'b0;
    stop_clr   = 1'b0;
    stop_floor = floor_idx;
    case (state)
      ST_HOMING: if (sw_any) state_n = ST_IDLE;
      ST_IDLE: begin
        if (pending[floor_idx]) begin
          state_n   = ST_DOOR;
          stop_clr  = 1'b1;
          door_load = 1'b1;
        end else if (any_above) begin
          state_n = ST_UP;
          dir_n   = 1'b1;
        end else if (any_below) begin
          state_n = ST_DOWN;
          dir_n   = 1'b0;
        end
      end
      ST_UP: if (sw_any) begin
        if (pending[sw_idx]) begin
          state_n    = ST_DOOR;
          stop_clr   = 1'b1;
          stop_floor = sw_idx;
          door_load  = 1'b1;
        end else if (sw_idx == FW'(FLOORS - 1)) begin
          state_n = ST_IDLE;
        end
      end
      ST_DOWN: if (sw_any) begin
        if (pending[sw_idx]) begin
          state_n    = ST_DOOR;
          stop_clr   = 1'b1;
          stop_floor = sw_idx;
          door_load  = 1'b1;
        end else if (sw_idx == '0) begin
          state_n = ST_IDLE;
        end
      end
      ST_DOOR: begin
        // A call at this floor holds the door instead of queueing a new stop.
        if (call[floor_idx]) begin
          door_load = 1'b1;
        end else if (door_done) begin
          // SCAN: keep going the same way while work remains ahead, else turn.
          if (dir ? any_above : any_below) begin
            state_n = dir ? ST_UP : ST_DOWN;
          end else if (dir ? any_below : any_above) begin
            state_n = dir ? ST_DOWN : ST_UP;
            dir_n   = !dir;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_HOMING;
    endcase
`ifdef ELEVADOR_FAULT_EN
    if (state == ST_FAULT || fault_cond) begin
      state_n   = ST_FAULT;
      door_load = 1'b0;
      stop_clr  = 1'b0;
    end
`endif
  end

  always_comb begin
    call_eff = call;
    if (state == ST_DOOR) call_eff[floor_idx] = 1'b0;
    pending_n = pending | call_eff;
    if (stop_clr) pending_n[stop_floor] = 1'b0;
  end

  // Motor and door outputs follow the next state so a stop takes effect on the sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HOMING;
      dir       <= 1'b1;
      pending   <= '0;
      floor_idx <= '0;
      Mup       <= 1'b0;
      Mdown     <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      pending   <= pending_n;
      if (sw_any) floor_idx <= sw_idx;
      Mup       <= (state_n == ST_UP);
      Mdown     <= (state_n == ST_DOWN) || (state_n == ST_HOMING);
      door_open <= (state_n == ST_DOOR);
    end
  end

endmodule

// File: tb/tb_elevador_multipiso.sv
// Bench for elevador_multipiso (FLOORS=4, DOOR_CYCLES=8, TRAVEL_MAX=64).
// Stimulus pushes each expected output snapshot (and optionally how long it must hold);
// a negedge monitor pops one entry on every change of the DUT outputs and compares it.
module tb_elevador_multipiso;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] call, sw;
  logic       Mup, Mdown, door_open, fault;
  logic [1:0] floor_idx;
  logic [3:0] pending;

  typedef struct packed {
    logic       mup;
    logic       mdn;
    logic       door;
    logic [1:0] fl;
    logic [3:0] pend;
    logic       flt;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dur;   // cycles this snapshot must persist, -1 = unchecked
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  elevador_multipiso #(.FLOORS(4), .DOOR_CYCLES(8), .TRAVEL_MAX(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .call      (call),
    .sw        (sw),
    .Mup       (Mup),
    .Mdown     (Mdown),
    .door_open (door_open),
    .floor_idx (floor_idx),
    .pending   (pending),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_snap(input logic mup, input logic mdn, input logic door,
                             input logic [1:0] fl, input logic [3:0] pend,
                             input logic flt, input int dur);
    exp_t e;
    e.s   = {mup, mdn, door, fl, pend, flt};
    e.dur = dur;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    snap_t prev, cur;
    exp_t  e;
    bit    have;
    int    held, want_dur;
    have = 1'b0;
    held = 0;
    want_dur = -1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {Mup, Mdown, door_open, floor_idx, pending, fault};
        n_chk++;
        if ((Mup && Mdown) || (door_open && (Mup || Mdown))) begin
          n_fail++;
          $display("FAIL interlock t=%0t got Mup=%b Mdown=%b door=%b want no overlap",
                   $time, Mup, Mdown, door_open);
        end
        if (!have || cur !== prev) begin
          if (have && want_dur >= 0) begin
            n_chk++;
            if (held != want_dur) begin
              n_fail++;
              $display("FAIL hold_time t=%0t snapshot %b held %0d cycles, want %0d",
                       $time, prev, held, want_dur);
            end
          end
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            want_dur = -1;
            $display("FAIL unexpected_change t=%0t got %b, want no change", $time, cur);
          end else begin
            e = q.pop_front();
            n_chk++;
            if (cur !== e.s) begin
              n_fail++;
              $display("FAIL snapshot t=%0t got {up,dn,door,fl,pend,flt}=%b want %b",
                       $time, cur, e.s);
            end
            want_dur = e.dur;
          end
          prev = cur;
          have = 1'b1;
          held = 1;
        end else begin
          held++;
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; sw = 4'b0000; call = 4'b0000;

    // Reset and homing descent to floor 0
    expect_snap(0, 0, 0, 2'd0, 4'b0000, 0, -1);
    tick(2); mon_en = 1'b1; tick(18);
    rst = 1'b0; expect_snap(0, 1, 0, 2'd0, 4'b0000, 0, 4); tick(4);
    sw = 4'b0001; expect_snap(0, 0, 0, 2'd0, 4'b0000, 0, -1); tick(3);

    // Floor 0: calls 2 then 1 while rising -> stop at 1, then 2
    call = 4'b0100; expect_snap(0, 0, 0, 2'd0, 4'b0100, 0, 1); tick(1);
    call = 4'b0000; expect_snap(1, 0, 0, 2'd0, 4'b0100, 0, -1); tick(1);
    sw = 4'b0000; call = 4'b0010; expect_snap(1, 0, 0, 2'd0, 4'b0110, 0, -1); tick(1);
    call = 4'b0000; tick(2);
    sw = 4'b0010; expect_snap(0, 0, 1, 2'd1, 4'b0100, 0, 8); tick(8);
    expect_snap(1, 0, 0, 2'd1, 4'b0100, 0, -1); tick(1);
    sw = 4'b0000; tick(3);
    sw = 4'b0100; expect_snap(0, 0, 1, 2'd2, 4'b0000, 0, 8); tick(8);
    expect_snap(0, 0, 0, 2'd2, 4'b0000, 0, -1); tick(2);

    // Reset while rising between floors, then homing again
    call = 4'b1000; expect_snap(0, 0, 0, 2'd2, 4'b1000, 0, 1); tick(1);
    call = 4'b0000; expect_snap(1, 0, 0, 2'd2, 4'b1000, 0, 4); tick(1);
    sw = 4'b0000; tick(3);
    rst = 1'b1; expect_snap(0, 0, 0, 2'd0, 4'b0000, 0, 3); tick(3);
    rst = 1'b0; expect_snap(0, 1, 0, 2'd0, 4'b0000, 0, -1); tick(4);
    sw = 4'b0001; expect_snap(0, 0, 0, 2'd0, 4'b0000, 0, -1); tick(2);

    // Floor 0 -> call 3, passes 1 and 2, door at 3 for 8 cycles
    call = 4'b1000; expect_snap(0, 0, 0, 2'd0, 4'b1000, 0, 1); tick(1);
    call = 4'b0000; expect_snap(1, 0, 0, 2'd0, 4'b1000, 0, 3); tick(1);
    sw = 4'b0000; tick(2);
    sw = 4'b0010; expect_snap(1, 0, 0, 2'd1, 4'b1000, 0, -1); tick(1);
    sw = 4'b0000; tick(2);
    sw = 4'b0100; expect_snap(1, 0, 0, 2'd2, 4'b1000, 0, -1); tick(1);
    sw = 4'b0000; tick(2);
    sw = 4'b1000; expect_snap(0, 0, 1, 2'd3, 4'b0000, 0, 8); tick(8);
    expect_snap(0, 0, 0, 2'd3, 4'b0000, 0, -1); tick(2);

    // Floor 3 descending to 0, call for 3 mid-travel -> finish at 0, reverse to 3
    call = 4'b0001; expect_snap(0, 0, 0, 2'd3, 4'b0001, 0, 1); tick(1);
    call = 4'b0000; expect_snap(0, 1, 0, 2'd3, 4'b0001, 0, -1); tick(1);
    sw = 4'b0000; tick(1);
    call = 4'b1000; expect_snap(0, 1, 0, 2'd3, 4'b1001, 0, -1); tick(1);
    call = 4'b0000; tick(1);
    sw = 4'b0100; expect_snap(0, 1, 0, 2'd2, 4'b1001, 0, -1); tick(1);
    sw = 4'b0000; tick(2);
    sw = 4'b0010; expect_snap(0, 1, 0, 2'd1, 4'b1001, 0, -1); tick(1);
    sw = 4'b0000; tick(2);
    sw = 4'b0001; expect_snap(0, 0, 1, 2'd0, 4'b1000, 0, 8); tick(8);
    expect_snap(1, 0, 0, 2'd0, 4'b1000, 0, -1); tick(1);
    sw = 4'b0000; tick(2);
    sw = 4'b0010; expect_snap(1, 0, 0, 2'd1, 4'b1000, 0, -1); tick(1);
    sw = 4'b0000; tick(2);
    sw = 4'b0100; expect_snap(1, 0, 0, 2'd2, 4'b1000, 0, -1); tick(1);
    sw = 4'b0000; tick(2);
    // Door at 3; a call for floor 3 on its 5th edge restarts the 8-cycle count
    sw = 4'b1000; expect_snap(0, 0, 1, 2'd3, 4'b0000, 0, 12); tick(4);
    call = 4'b1000; tick(1);
    call = 4'b0000; tick(7);
    expect_snap(0, 0, 0, 2'd3, 4'b0000, 0, -1); tick(3);

`ifdef ELEVADOR_FAULT_EN
    // Watchdog: motor on with switches frozen at 0000
    call = 4'b0001; expect_snap(0, 0, 0, 2'd3, 4'b0001, 0, 1); tick(1);
    call = 4'b0000; expect_snap(0, 1, 0, 2'd3, 4'b0001, 0, -1); tick(1);
    sw = 4'b0000; expect_snap(0, 0, 0, 2'd3, 4'b0001, 1, -1); tick(70);
    tick(10);
    rst = 1'b1; expect_snap(0, 0, 0, 2'd0, 4'b0000, 0, -1); tick(2);
    rst = 1'b0; expect_snap(0, 1, 0, 2'd0, 4'b0000, 0, -1); tick(2);
    // Two switches high at once
    sw = 4'b0110; expect_snap(0, 0, 0, 2'd1, 4'b0000, 1, -1); tick(6);
`else
    // Two switches high at once: lowest index wins, no fault
    sw = 4'b0110; expect_snap(0, 0, 0, 2'd1, 4'b0000, 0, -1); tick(4);
`endif

    tick(3);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations got %0d pending entries, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
